// File: rtl/axi_cdc_isolate_ctrl.sv
// axi_cdc_isolate_ctrl
// Destination-side isolation sequencer for the AXI CDC wrapper. Counts outstanding write and read
// transactions from observed handshakes, blocks new AW/AR on an isolation request, and raises
// isolate_o only once every in-flight burst has completed. Also caps outstanding transactions
// at MaxTxns per direction.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   isolate_req_i           level isolation request (deassert to release)
//   aw/w/b/ar/r *_valid_i, *_ready_i, w_last_i, r_last_i   handshakes seen at the slave
//   block_ax_o              gates AW/AR; no new address accepted while high
//   isolate_o               drives the wrapper isolate input
//   wr_outstanding_o        AW accepted minus B accepted
//   rd_outstanding_o        AR accepted minus R-last accepted
//   w_balance_o             signed, AW accepted minus W-last accepted
//   err_o                   sticky protocol error, cleared by reset only
module axi_cdc_isolate_ctrl #(
   parameter int unsigned MaxTxns = 8,
   localparam int unsigned CntW = $clog2(MaxTxns + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            isolate_req_i,
   input  logic            aw_valid_i,
   input  logic            aw_ready_i,
   input  logic            w_valid_i,
   input  logic            w_ready_i,
   input  logic            w_last_i,
   input  logic            b_valid_i,
   input  logic            b_ready_i,
   input  logic            ar_valid_i,
   input  logic            ar_ready_i,
   input  logic            r_valid_i,
   input  logic            r_ready_i,
   input  logic            r_last_i,
   output logic            block_ax_o,
   output logic            isolate_o,
   output logic [CntW-1:0] wr_outstanding_o,
   output logic [CntW-1:0] rd_outstanding_o,
   output logic [CntW:0]   w_balance_o,
   output logic            err_o
);

   localparam int unsigned BalW = CntW + 1;
   localparam logic [CntW-1:0]       MaxCnt = CntW'(MaxTxns);
   localparam logic signed [BalW-1:0] BalMax = BalW'(MaxTxns);
   localparam logic signed [BalW-1:0] BalMin = -BalMax;

   localparam logic [1:0] StRun      = 2'd0;
   localparam logic [1:0] StDrain    = 2'd1;
   localparam logic [1:0] StIsolated = 2'd2;

   logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
   assign aw_hs     = aw_valid_i & aw_ready_i;
   assign w_last_hs = w_valid_i & w_ready_i & w_last_i;
   assign b_hs      = b_valid_i & b_ready_i;
   assign ar_hs     = ar_valid_i & ar_ready_i;
   assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

   logic [CntW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic signed [BalW-1:0] bal_q, bal_d;
   logic [1:0]             state_q, state_d;
   logic                   err_q, err_d;
   logic                   wr_err, rd_err, bal_err;

   // Simultaneous increment and decrement cancel; an out-of-range step holds the counter.
   always_comb begin
      wr_d   = wr_q;
      wr_err = 1'b0;
      if (aw_hs && !b_hs) begin
         if (wr_q == MaxCnt) wr_err = 1'b1;
         else                wr_d   = wr_q + CntW'(1);
      end else if (b_hs && !aw_hs) begin
         if (wr_q == '0) wr_err = 1'b1;
         else            wr_d   = wr_q - CntW'(1);
      end
   end

   always_comb begin
      rd_d   = rd_q;
      rd_err = 1'b0;
      if (ar_hs && !r_last_hs) begin
         if (rd_q == MaxCnt) rd_err = 1'b1;
         else                rd_d   = rd_q + CntW'(1);
      end else if (r_last_hs && !ar_hs) begin
         if (rd_q == '0) rd_err = 1'b1;
         else            rd_d   = rd_q - CntW'(1);
      end
   end

   // W may lead AW, so the balance runs negative down to -MaxTxns.
   always_comb begin
      bal_d   = bal_q;
      bal_err = 1'b0;
      if (aw_hs && !w_last_hs) begin
         if (bal_q == BalMax) bal_err = 1'b1;
         else                 bal_d   = bal_q + BalW'(1);
      end else if (w_last_hs && !aw_hs) begin
         if (bal_q == BalMin) bal_err = 1'b1;
         else                 bal_d   = bal_q - BalW'(1);
      end
   end

   assign err_d = err_q | wr_err | rd_err | bal_err;

   // Drain completion looks at next-state counts so the final handshake isolates one cycle later.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (isolate_req_i) state_d = StDrain;
         end
         StDrain: begin
            if (!isolate_req_i) state_d = StRun;
            else if (wr_d == '0 && rd_d == '0 && bal_d == '0) state_d = StIsolated;
         end
         StIsolated: begin
            if (!isolate_req_i) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StRun;
         wr_q    <= '0;
         rd_q    <= '0;
         bal_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         bal_q   <= bal_d;
         err_q   <= err_d;
      end
   end

   assign isolate_o        = (state_q == StIsolated);
   assign block_ax_o       = (state_q != StRun) | (wr_q == MaxCnt) | (rd_q == MaxCnt);
   assign wr_outstanding_o = wr_q;
   assign rd_outstanding_o = rd_q;
   assign w_balance_o      = bal_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_axi_cdc_isolate_ctrl.sv
// Self-checking bench for axi_cdc_isolate_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-count reference model.
module tb_axi_cdc_isolate_ctrl;

   localparam int MAXT = 8;
   localparam int CW   = $clog2(MAXT + 1);

   logic clk = 1'b0;
   logic rst_i, isolate_req_i;
   logic aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i, b_valid_i, b_ready_i;
   logic ar_valid_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i;
   logic          block_ax_o, isolate_o, err_o;
   logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;
   logic [CW:0]   w_balance_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: plain transaction counts and a mode (0 run, 1 draining, 2 isolated).
   int m_wr = 0, m_rd = 0, m_bal = 0, m_mode = 0;
   bit m_err = 0;

   axi_cdc_isolate_ctrl #(.MaxTxns(MAXT)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .isolate_req_i    (isolate_req_i),
      .aw_valid_i       (aw_valid_i),
      .aw_ready_i       (aw_ready_i),
      .w_valid_i        (w_valid_i),
      .w_ready_i        (w_ready_i),
      .w_last_i         (w_last_i),
      .b_valid_i        (b_valid_i),
      .b_ready_i        (b_ready_i),
      .ar_valid_i       (ar_valid_i),
      .ar_ready_i       (ar_ready_i),
      .r_valid_i        (r_valid_i),
      .r_ready_i        (r_ready_i),
      .r_last_i         (r_last_i),
      .block_ax_o       (block_ax_o),
      .isolate_o        (isolate_o),
      .wr_outstanding_o (wr_outstanding_o),
      .rd_outstanding_o (rd_outstanding_o),
      .w_balance_o      (w_balance_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic idle();
      aw_valid_i = 0; aw_ready_i = 0; w_valid_i = 0; w_ready_i = 0; w_last_i = 0;
      b_valid_i = 0; b_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
      r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
   endtask

   function automatic bit m_block();
      return (m_mode != 0) || (m_wr == MAXT) || (m_rd == MAXT);
   endfunction

   task automatic model_step();
      int aw, wl, b, ar, rl, nwr, nrd, nbal;
      aw = int'(aw_valid_i & aw_ready_i);
      wl = int'(w_valid_i & w_ready_i & w_last_i);
      b  = int'(b_valid_i & b_ready_i);
      ar = int'(ar_valid_i & ar_ready_i);
      rl = int'(r_valid_i & r_ready_i & r_last_i);
      if (rst_i) begin
         m_wr = 0; m_rd = 0; m_bal = 0; m_mode = 0; m_err = 0;
         return;
      end
      nwr  = m_wr + aw - b;
      nrd  = m_rd + ar - rl;
      nbal = m_bal + aw - wl;
      if (nwr < 0 || nwr > MAXT) begin m_err = 1; nwr = m_wr; end
      if (nrd < 0 || nrd > MAXT) begin m_err = 1; nrd = m_rd; end
      if (nbal < -MAXT || nbal > MAXT) begin m_err = 1; nbal = m_bal; end
      if (!isolate_req_i) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && nwr == 0 && nrd == 0 && nbal == 0) m_mode = 2;
      m_wr = nwr; m_rd = nrd; m_bal = nbal;
   endtask

   task automatic check_all();
      chk("isolate", 32'(isolate_o), 32'(m_mode == 2));
      chk("block", 32'(block_ax_o), 32'(m_block()));
      chk("wr_out", 32'(wr_outstanding_o), m_wr);
      chk("rd_out", 32'(rd_outstanding_o), m_rd);
      chk("w_bal", 32'($signed(w_balance_o)), m_bal);
      chk("err", 32'(err_o), 32'(m_err));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      idle(); isolate_req_i = 0; rst_i = 1; cyc(); rst_i = 0;
   endtask

   initial begin
      idle(); isolate_req_i = 0; rst_i = 1;
      @(posedge clk); #1;
      cyc();
      rst_i = 0;
      chk("reset_block", 32'(block_ax_o), 0);
      chk("reset_iso", 32'(isolate_o), 0);

      // Idle isolate
      isolate_req_i = 1; cyc();
      chk("idle_block_c1", 32'(block_ax_o), 1);
      chk("idle_iso_c1", 32'(isolate_o), 0);
      cyc();
      chk("idle_iso_c2", 32'(isolate_o), 1);
      cyc(); cyc(); cyc();
      isolate_req_i = 0; cyc();
      chk("idle_rel_iso", 32'(isolate_o), 0);
      chk("idle_rel_block", 32'(block_ax_o), 0);

      // Drain writes: two 8-beat bursts
      do_reset();
      aw_valid_i = 1; aw_ready_i = 1; cyc(); cyc(); idle();
      isolate_req_i = 1; cyc();
      chk("drain_wr_cnt", 32'(wr_outstanding_o), 2);
      for (int burst = 0; burst < 2; burst++) begin
         for (int beat = 0; beat < 8; beat++) begin
            w_valid_i = 1; w_ready_i = 1; w_last_i = (beat == 7); cyc();
         end
      end
      idle();
      chk("drain_wbal0", 32'($signed(w_balance_o)), 0);
      b_valid_i = 1; b_ready_i = 1; cyc(); idle();
      chk("drain_b1_iso", 32'(isolate_o), 0);
      cyc();
      b_valid_i = 1; b_ready_i = 1; cyc(); idle();
      chk("drain_b2_iso", 32'(isolate_o), 1);
      isolate_req_i = 0; cyc();

      // Reads with simultaneous AR and R-last
      do_reset();
      ar_valid_i = 1; ar_ready_i = 1; cyc();
      r_valid_i = 1; r_ready_i = 1; r_last_i = 1; cyc(); idle();
      chk("rd_simul", 32'(rd_outstanding_o), 1);
      isolate_req_i = 1; cyc();
      r_valid_i = 1; r_ready_i = 1; r_last_i = 1; cyc(); idle();
      chk("rd_final_iso", 32'(isolate_o), 1);
      isolate_req_i = 0; cyc();

      // Flow control
      do_reset();
      for (int i = 0; i < MAXT; i++) begin
         ar_valid_i = 1; ar_ready_i = 1; cyc();
      end
      idle();
      chk("fc_block", 32'(block_ax_o), 1);
      chk("fc_iso", 32'(isolate_o), 0);
      r_valid_i = 1; r_ready_i = 1; r_last_i = 1; cyc(); idle();
      chk("fc_rd7", 32'(rd_outstanding_o), 7);
      chk("fc_unblock", 32'(block_ax_o), 0);

      // Abort and error
      do_reset();
      aw_valid_i = 1; aw_ready_i = 1; cyc(); idle();
      isolate_req_i = 1; cyc(); cyc();
      isolate_req_i = 0; cyc();
      chk("abort_iso", 32'(isolate_o), 0);
      chk("abort_block", 32'(block_ax_o), 0);
      b_valid_i = 1; b_ready_i = 1; cyc(); cyc(); idle();
      chk("err_set", 32'(err_o), 1);
      chk("err_cnt0", 32'(wr_outstanding_o), 0);
      cyc(); cyc();
      chk("err_sticky", 32'(err_o), 1);

      // Reset mid-drain
      do_reset();
      aw_valid_i = 1; aw_ready_i = 1; cyc(); cyc(); cyc(); idle();
      isolate_req_i = 1; cyc();
      chk("mid_wr3", 32'(wr_outstanding_o), 3);
      rst_i = 1; cyc(); rst_i = 0;
      chk("mid_rst_wr", 32'(wr_outstanding_o), 0);
      chk("mid_rst_block", 32'(block_ax_o), 0);
      isolate_req_i = 0; cyc();

      // Random traffic, mostly protocol-legal
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit legal;
         legal = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 99) < 4) isolate_req_i = ~isolate_req_i;
         rst_i = ($urandom_range(0, 499) == 0);
         aw_valid_i = $urandom_range(0, 2) == 0 && (!m_block() || !legal);
         aw_ready_i = $urandom_range(0, 1);
         ar_valid_i = $urandom_range(0, 2) == 0 && (!m_block() || !legal);
         ar_ready_i = $urandom_range(0, 1);
         w_valid_i  = $urandom_range(0, 1);
         w_ready_i  = $urandom_range(0, 1);
         w_last_i   = $urandom_range(0, 3) == 0 && (m_bal > -MAXT || !legal);
         b_valid_i  = $urandom_range(0, 2) == 0 && (m_wr > 0 || !legal);
         b_ready_i  = $urandom_range(0, 1);
         r_valid_i  = $urandom_range(0, 1);
         r_ready_i  = $urandom_range(0, 1);
         r_last_i   = $urandom_range(0, 2) == 0 && (m_rd > 0 || !legal);
         cyc();
      end
      idle(); rst_i = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_cdc_isolate_ctrl.md
Name: axi_cdc_isolate_ctrl

Overview:
- Single-clock controller on the destination side of the AXI CDC wrapper.
- Sequences safe isolation of the wrapper: counts outstanding write/read transactions from observed handshakes, blocks new AW/AR on isolation request, and waits for all in-flight bursts to complete. Only then does it assert `isolate_o`, which drives the wrapper's isolate input.
- Also provides outstanding-transaction flow control, capping outstanding transactions at `MaxTxns` per direction.

Parameters:
- `MaxTxns`, default 8: maximum outstanding transactions per direction (writes awaiting B, reads awaiting last R); must be ≥ 1.
- `CntW`, default `$clog2(MaxTxns+1)`: width of the outstanding counters (derived, not overridable).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `isolate_req_i`  in  1  level request to isolate; deassert to release.
- `aw_valid_i`, `aw_ready_i`  in  1 each  AW handshake as seen at the downstream slave (post-gating).
- `w_valid_i`, `w_ready_i`, `w_last_i`  in  1 each  W handshake and last flag.
- `b_valid_i`, `b_ready_i`  in  1 each  B handshake.
- `ar_valid_i`, `ar_ready_i`  in  1 each  AR handshake.
- `r_valid_i`, `r_ready_i`, `r_last_i`  in  1 each  R handshake and last flag.
- `block_ax_o`  out  1  gates AW/AR ready and valid; no new address accepted while high.
- `isolate_o`  out  1  drives the wrapper isolate input.
- `wr_outstanding_o`  out  CntW  AW accepted minus B accepted.
- `rd_outstanding_o`  out  CntW  AR accepted minus R-last accepted.
- `w_balance_o`  out  CntW+1  signed; AW accepted minus W-last accepted.
- `err_o`  out  1  sticky protocol error.

Behaviour:
- **Handshake events.** An event fires on `valid & ready` in the same cycle: `aw_hs`, `w_last_hs` (W handshake with `w_last_i`), `b_hs`, `ar_hs`, `r_last_hs`.
- **Counters** (all registered; outputs are the register values):
  - `wr_cnt` += `aw_hs`, −= `b_hs`. If both fire in one cycle, the count is unchanged.
  - `rd_cnt` += `ar_hs`, −= `r_last_hs`. Same-cycle rule as above.
  - `w_bal` += `aw_hs`, −= `w_last_hs`. Signed; W may lead AW per AXI, so negative values are legal down to −`MaxTxns`.
- **Error conditions** (each holds the affected counter and sets `err_o`):
  - decrement of `wr_cnt` or `rd_cnt` at 0;
  - increment of `wr_cnt` or `rd_cnt` at `MaxTxns`;
  - `w_bal` leaving [−`MaxTxns`, `MaxTxns`].
- `err_o` clears only on reset.
- **FSM** (registered state), values RUN, DRAIN, ISOLATED:
  - RUN: `isolate_req_i`=1 → DRAIN next cycle.
  - DRAIN: `isolate_req_i`=0 → RUN (abort). Otherwise, if `wr_cnt`=0, `rd_cnt`=0 and `w_bal`=0, evaluated on next-state counter values including this cycle's events → ISOLATED.
  - ISOLATED: `isolate_req_i`=0 → RUN. Otherwise stay.
- **Outputs:**
  - `isolate_o` = (state==ISOLATED). It is a pure function of the state register, so it rises exactly 1 cycle after the drain condition is met.
  - `block_ax_o` = (state≠RUN) | (`wr_cnt`==`MaxTxns`) | (`rd_cnt`==`MaxTxns`). Decoded from registers only; no combinational path from any input.
- **Ordering guarantees:**
  - An AW/AR handshake in the same cycle `isolate_req_i` rises is still counted and must drain before isolation.
  - While `block_ax_o`=1, W/B/R traffic continues unimpeded so outstanding bursts can complete.
- **Reset** (synchronous, `rst_i`=1 at a clock edge, any state, including mid-burst):
  - state=RUN; all counters 0; `err_o`=0; `isolate_o`=0; `block_ax_o`=0.
  - The controller does not track traffic in flight at reset; the system resets the wrapper FIFOs in the same cycle.
- **Latency:** request to `block_ax_o` = 1 cycle. Last completing handshake to `isolate_o` = 1 cycle. Release to `isolate_o`=0 and `block_ax_o`=0 = 1 cycle.

Test Plan:
- **Idle isolate:** reset; `isolate_req_i`=1 at cycle 0 with no traffic → `block_ax_o`=1 at cycle 1, `isolate_o`=1 at cycle 2. Deassert at cycle 5 → both 0 at cycle 6.
- **Drain writes:** 2 AW accepted, 8-beat bursts, request asserted after AW #2 → `wr_outstanding_o`=2. `isolate_o` stays 0 until the 2nd B handshake and rises the next cycle; `w_balance_o` reaches 0 after 2 W-last.
- **Drain reads with simultaneous events:** AR and R-last in the same cycle with `rd_cnt`=1 → count stays 1. Final R-last during DRAIN → ISOLATED next cycle.
- **Flow control:** `MaxTxns`=8; issue 8 AR with no R → `block_ax_o`=1 with state RUN. One R-last → `rd_outstanding_o`=7, `block_ax_o`=0 the next cycle.
- **Abort and error:** request, then deassert while `wr_cnt`=1 → back to RUN, `isolate_o` never 1. A B handshake with `wr_cnt`=0 → `err_o`=1, counter stays 0, `err_o` still 1 until `rst_i`.
- **Reset mid-DRAIN:** `wr_cnt`=3, state DRAIN, `rst_i`=1 → next cycle all counters 0, `block_ax_o`=0, `isolate_o`=0, `err_o`=0.
